muldiv_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit with HI/LO registers for the MIPS datapath. It sits beside the single-cycle ALU in the execute stage and takes the R-type `funct` field directly. It decodes the HI/LO instruction group (mult, multu, div, divu, mfhi, mflo, mthi, mtlo) and sequences iterative shift-add multiplication and restoring division. It signals completion with a start/busy/done handshake so the pipeline control can stall.

---
 rtl/muldiv_unit.sv | 196 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the MIPS execute stage.
// Moves complete in 1 cycle. mult/div take WIDTH cycles busy plus one done cycle.
// start is accepted only in IDLE/DONE and ignored while busy, so the pipeline stalls on busy.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  // acc: partial product high half / partial remainder
  // sh : multiplier being consumed / dividend shifting into quotient
  // opnd: multiplicand / divisor magnitude
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] opnd;
  logic             neg_q;
  logic             neg_r;
  logic             dz;

  logic             accept;
  logic             is_mul;
  logic             is_div;
  logic             is_move;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             last;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_acc_n;
  logic [WIDTH-1:0]   mul_sh_n;
  logic [2*WIDTH-1:0] mul_prod;
  logic [2*WIDTH-1:0] fin_mul;

  logic [WIDTH:0]   div_trial;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_acc_n;
  logic [WIDTH-1:0] div_sh_n;
  logic [WIDTH-1:0] fin_q;
  logic [WIDTH-1:0] fin_r;

  assign busy = (state == S_MUL) || (state == S_DIV);
  assign done = (state == S_DONE);

  // Decode the request and take operand magnitudes; funct[0]=0 selects the signed variant.
  always_comb begin
    accept  = start && ((state == S_IDLE) || (state == S_DONE));
    is_mul  = (funct == F_MULT) || (funct == F_MULTU);
    is_div  = (funct == F_DIV) || (funct == F_DIVU);
    is_move = (funct[5:2] == 4'b0100);
    a_neg   = ~funct[0] & op_a[WIDTH-1];
    b_neg   = ~funct[0] & op_b[WIDTH-1];
    abs_a   = a_neg ? -op_a : op_a;
    abs_b   = b_neg ? -op_b : op_b;
    last    = (cnt == CW'(WIDTH - 1));
  end

  // One shift-add multiply step and one restoring-divide step, plus final sign fix-up.
  always_comb begin
    mul_sum   = {1'b0, acc} + (sh[0] ? {1'b0, opnd} : '0);
    mul_acc_n = mul_sum[WIDTH:1];
    mul_sh_n  = {mul_sum[0], sh[WIDTH-1:1]};
    mul_prod  = {mul_acc_n, mul_sh_n};
    fin_mul   = neg_q ? -mul_prod : mul_prod;

    div_trial = {acc, sh[WIDTH-1]};
    div_ge    = (div_trial >= {1'b0, opnd});
    div_diff  = div_trial - {1'b0, opnd};
    div_acc_n = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
    div_sh_n  = {sh[WIDTH-2:0], div_ge};
    // A zero divisor leaves the full dividend magnitude in the remainder, so the
    // signed fix-up restores op_a exactly; only the quotient needs forcing.
    fin_q     = dz ? '1 : (neg_q ? -div_sh_n : div_sh_n);
    fin_r     = neg_r ? -div_acc_n : div_acc_n;
  end

  // Sequencer: state, step counter and the illegal-funct pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      illegal <= 1'b0;
    end else begin
      illegal <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            cnt <= '0;
            if (is_mul)       state <= S_MUL;
            else if (is_div)  state <= S_DIV;
            else if (is_move) state <= S_DONE;
            else begin
              state   <= S_IDLE;
              illegal <= 1'b1;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_MUL, S_DIV: begin
          if (last) begin
            state <= S_DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath: operand latch, iteration registers and HI/LO/result writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      sh     <= '0;
      opnd   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      result <= '0;
    end else if (accept) begin
      if (funct == F_MFHI) result <= hi;
      if (funct == F_MFLO) result <= lo;
      if (funct == F_MTHI) hi <= op_a;
      if (funct == F_MTLO) lo <= op_a;
      if (is_mul) begin
        acc   <= '0;
        sh    <= abs_b;
        opnd  <= abs_a;
        neg_q <= a_neg ^ b_neg;
        neg_r <= 1'b0;
        dz    <= 1'b0;
      end
      if (is_div) begin
        acc   <= '0;
        sh    <= abs_a;
        opnd  <= abs_b;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        dz    <= (op_b == '0);
      end
    end else if (state == S_MUL) begin
      acc <= mul_acc_n;
      sh  <= mul_sh_n;
      if (last) begin
        hi     <= fin_mul[2*WIDTH-1:WIDTH];
        lo     <= fin_mul[WIDTH-1:0];
        result <= fin_mul[WIDTH-1:0];
      end
    end else if (state == S_DIV) begin
      acc <= div_acc_n;
      sh  <= div_sh_n;
      if (last) begin
        hi     <= fin_r;
        lo     <= fin_q;
        result <= fin_q;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int W = 32;

  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MTHI  = 6'b010001;
  localparam logic [5:0] MFLO  = 6'b010010;
  localparam logic [5:0] MTLO  = 6'b010011;
  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIV   = 6'b011010;
  localparam logic [5:0] DIVU  = 6'b011011;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [5:0]   funct;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic         illegal;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W-1:0] result;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] res;
  } exp_t;

  exp_t sb[$];
  logic [W-1:0] m_hi, m_lo, m_res;
  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct(funct),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .illegal(illegal),
    .hi(hi), .lo(lo), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: architectural HI/LO/result after each op, pushed to the scoreboard.
  task automatic model_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    longint          sa = longint'($signed(a));
    longint          sbv = longint'($signed(b));
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    logic [63:0]     p;
    exp_t            e;
    case (f)
      MFHI: m_res = m_hi;
      MFLO: m_res = m_lo;
      MTHI: m_hi = a;
      MTLO: m_lo = a;
      MULT: begin p = 64'(sa * sbv); m_hi = p[63:32]; m_lo = p[31:0]; m_res = m_lo; end
      MULTU: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; m_res = m_lo; end
      DIV: begin
        if (b == 0) begin m_lo = '1; m_hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = a; m_hi = '0; end
        else begin m_lo = 32'(sa / sbv); m_hi = 32'(sa % sbv); end
        m_res = m_lo;
      end
      DIVU: begin
        if (b == 0) begin m_lo = '1; m_hi = a; end
        else begin m_lo = 32'(ua / ub); m_hi = 32'(ua % ub); end
        m_res = m_lo;
      end
      default: ;
    endcase
    e.hi = m_hi; e.lo = m_lo; e.res = m_res;
    sb.push_back(e);
  endtask

  // Issue one op at a negedge, optionally poke an extra start while it runs,
  // and check latency and busy length. Returns on the negedge where done is seen.
  task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int exp_lat, input int exp_busy, input int inject);
    int lat;
    int busy_n;
    model_op(f, a, b);
    start = 1'b1; funct = f; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_n = 0;
    while (!done && lat < 200) begin
      if (busy) busy_n++;
      if (lat == inject) begin
        start = 1'b1; funct = DIVU; op_a = 32'd9; op_b = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("latency", 64'(lat), 64'(exp_lat));
    check("busy_cycles", 64'(busy_n), 64'(exp_busy));
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      check("busy_with_done", 64'(busy), 64'd0);
      check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("hi", 64'(hi), 64'(e.hi));
        check("lo", 64'(lo), 64'(e.lo));
        check("result", 64'(result), 64'(e.res));
      end
    end
    if (rst_n && illegal) check("done_with_illegal", 64'(done), 64'd0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; funct = '0; op_a = '0; op_b = '0;
    m_hi = '0; m_lo = '0; m_res = '0;
    #12;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(MULT,  32'hFFFF_FFFF, 32'd2, W + 1, W, 0);
    run_op(MULTU, 32'hFFFF_FFFF, 32'd2, W + 1, W, 0);
    run_op(DIV,   32'hFFFF_FFF9, 32'd2, W + 1, W, 0);
    run_op(DIVU,  32'd7, 32'd2, W + 1, W, 0);
    run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, W + 1, W, 0);
    run_op(MULT,  32'hFFFF_FFFD, 32'd5, W + 1, W, 0);
    run_op(MFHI,  32'd0, 32'd0, 1, 0, 0);
    run_op(DIV,   32'hFFFF_FF9C, 32'd0, W + 1, W, 0);
    run_op(DIVU,  32'd5, 32'd0, W + 1, W, 0);
    @(negedge clk);
    check("divz_done_once", 64'(done), 64'd0);

    // mthi followed immediately by mfhi in the DONE cycle
    model_op(MTHI, 32'h1234_5678, 32'd0);
    start = 1'b1; funct = MTHI; op_a = 32'h1234_5678; op_b = '0;
    @(negedge clk);
    check("mthi_done", 64'(done), 64'd1);
    model_op(MFHI, 32'd0, 32'd0);
    funct = MFHI; op_a = '0;
    @(negedge clk);
    start = 1'b0;
    check("mfhi_done", 64'(done), 64'd1);
    check("mfhi_result", 64'(result), 64'h1234_5678);
    @(negedge clk);
    check("b2b_done_clear", 64'(done), 64'd0);

    run_op(MTLO,  32'hCAFE_0001, 32'd0, 1, 0, 0);
    run_op(MULTU, 32'hDEAD_BEEF, 32'h0001_0001, W + 1, W, 5);
    @(negedge clk);

    // unsupported funct in IDLE
    start = 1'b1; funct = 6'h20; op_a = 32'h5555_5555; op_b = 32'h1;
    @(negedge clk);
    start = 1'b0;
    check("illegal_pulse", 64'(illegal), 64'd1);
    check("illegal_done", 64'(done), 64'd0);
    check("illegal_hi", 64'(hi), 64'(m_hi));
    check("illegal_lo", 64'(lo), 64'(m_lo));
    check("illegal_result", 64'(result), 64'(m_res));
    @(negedge clk);
    check("illegal_one_cycle", 64'(illegal), 64'd0);

    // reset in the middle of a divide
    start = 1'b1; funct = DIV; op_a = 32'd100; op_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    m_hi = '0; m_lo = '0; m_res = '0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    check("arst_result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(MULT, 32'd3, 32'd4, W + 1, W, 0);
    @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
